// File: rtl/debounce_multi.sv
// debounce_multi: N-channel pushbutton debouncer with a shared sample-tick prescaler.
// Define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses on held buttons.
module debounce_multi #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 1000000,
  parameter int STABLE_TICKS = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] pb_press,
  output logic [N_CH-1:0] pb_release,
  output logic [N_CH-1:0] pb_repeat,
  output logic            tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [N_CH-1:0]  POL_MASK = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  if (N_CH < 1 || TICK_DIV < 1 || STABLE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("debounce_multi: all parameters must be >= 1");
  end

  logic [N_CH-1:0]  sync_meta_r;
  logic [N_CH-1:0]  sync_r;
  logic [DIV_W-1:0] div_r;
  logic             tick_en_s;
  logic [N_CH-1:0]  sample_s;
  logic [CNT_W-1:0] cnt_r     [N_CH];
  logic [CNT_W-1:0] cnt_nxt_s [N_CH];
  logic [N_CH-1:0]  level_nxt_s;
  logic [N_CH-1:0]  commit_press_s;
  logic [N_CH-1:0]  commit_release_s;
  logic [N_CH-1:0]  press_all_s;

  assign tick_en_s = (div_r == DIV_LAST);
  assign sample_s  = sync_r ^ POL_MASK;

  // Synchroniser, prescaler and exported tick (tick is aligned with the output pulses).
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta_r <= {N_CH{1'b0}};
      sync_r      <= {N_CH{1'b0}};
      div_r       <= {DIV_W{1'b0}};
      tick        <= 1'b0;
    end else begin
      sync_meta_r <= pb;
      sync_r      <= sync_meta_r;
      div_r       <= tick_en_s ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
      tick        <= tick_en_s;
    end
  end

  // Per-channel stability counting; a matching sample always restarts the count.
  always_comb begin
    cnt_nxt_s        = cnt_r;
    level_nxt_s      = pb_level;
    commit_press_s   = {N_CH{1'b0}};
    commit_release_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (!tick_en_s) begin
        cnt_nxt_s[i] = cnt_r[i];
      end else if (sample_s[i] == pb_level[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == CNT_LAST) begin
        cnt_nxt_s[i]        = {CNT_W{1'b0}};
        level_nxt_s[i]      = sample_s[i];
        commit_press_s[i]   = sample_s[i];
        commit_release_s[i] = ~sample_s[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Debounced level, pulse outputs and stability counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      pb_level   <= {N_CH{1'b0}};
      pb_press   <= {N_CH{1'b0}};
      pb_release <= {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      pb_level   <= level_nxt_s;
      pb_press   <= press_all_s;
      pb_release <= commit_release_s;
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic [REP_W-1:0] rep_cnt_r     [N_CH];
  logic [REP_W-1:0] rep_cnt_nxt_s [N_CH];
  logic [N_CH-1:0]  rep_phase_r;
  logic [N_CH-1:0]  rep_phase_nxt_s;
  logic [N_CH-1:0]  repeat_nxt_s;

  // Hold timer: first pulse after the delay, then one every rate period; none on the release tick.
  always_comb begin
    rep_cnt_nxt_s   = rep_cnt_r;
    rep_phase_nxt_s = rep_phase_r;
    repeat_nxt_s    = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (!pb_level[i]) begin
        rep_cnt_nxt_s[i]   = {REP_W{1'b0}};
        rep_phase_nxt_s[i] = 1'b0;
      end else if (tick_en_s && !commit_release_s[i]) begin
        if (!rep_phase_r[i] && rep_cnt_r[i] == REP_DELAY_LAST) begin
          repeat_nxt_s[i]    = 1'b1;
          rep_cnt_nxt_s[i]   = {REP_W{1'b0}};
          rep_phase_nxt_s[i] = 1'b1;
        end else if (rep_phase_r[i] && rep_cnt_r[i] == REP_RATE_LAST) begin
          repeat_nxt_s[i]  = 1'b1;
          rep_cnt_nxt_s[i] = {REP_W{1'b0}};
        end else begin
          rep_cnt_nxt_s[i] = rep_cnt_r[i] + REP_W'(1);
        end
      end else begin
        rep_cnt_nxt_s[i] = rep_cnt_r[i];
      end
    end
  end

  // Repeat counters and repeat pulse register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rep_phase_r <= {N_CH{1'b0}};
      pb_repeat   <= {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
        rep_cnt_r[i] <= {REP_W{1'b0}};
      end
    end else begin
      rep_phase_r <= rep_phase_nxt_s;
      pb_repeat   <= repeat_nxt_s;
      for (int i = 0; i < N_CH; i++) begin
        rep_cnt_r[i] <= rep_cnt_nxt_s[i];
      end
    end
  end

  assign press_all_s = commit_press_s | repeat_nxt_s;
`else
  assign pb_repeat   = {N_CH{1'b0}};
  assign press_all_s = commit_press_s;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus pushes expected pulse events,
// a negedge monitor pops and compares them whenever any pulse output is active.
module tb_debounce_multi;
  localparam int N_CH = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N_CH-1:0] pb = 4'h0;
  logic [N_CH-1:0] pb_level, pb_press, pb_release, pb_repeat;
  logic            tick;

  debounce_multi #(
    .N_CH(4), .TICK_DIV(4), .STABLE_TICKS(4), .ACTIVE_LOW(1),
    .REPEAT_DELAY(6), .REPEAT_RATE(3)
  ) dut (
    .clock(clock), .reset(reset), .pb(pb),
    .pb_level(pb_level), .pb_press(pb_press), .pb_release(pb_release),
    .pb_repeat(pb_repeat), .tick(tick)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
    logic [3:0] lvl;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] t, input logic [3:0] l);
    ev_t e;
    e.cyc = c; e.prs = p; e.rel = r; e.rpt = t; e.lvl = l;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Monitor: every active pulse must match the oldest expected event in cycle and value.
  always @(negedge clock) begin : monitor
    ev_t e;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse: nothing by cycle %0d, expected press=%h release=%h repeat=%h",
                 e.cyc, e.prs, e.rel, e.rpt);
      end
      if ((pb_press | pb_release | pb_repeat) != 4'h0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse at cycle %0d: press=%h release=%h repeat=%h",
                   cyc, pb_press, pb_release, pb_repeat);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pb_press", {28'h0, pb_press}, {28'h0, e.prs});
          check("pb_release", {28'h0, pb_release}, {28'h0, e.rel});
          check("pb_repeat", {28'h0, pb_repeat}, {28'h0, e.rpt});
          check("pb_level_at_pulse", {28'h0, pb_level}, {28'h0, e.lvl});
          check("tick_with_pulse", {31'h0, tick}, 32'h1);
        end
      end
    end
  end

  int r, s, t, u, v, w, r2, r3;

  initial begin
    // 1: pins pressed through reset, all channels commit 16 clocks after release
    pb = 4'h0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    mon_en = 1'b1;
    check("level_in_reset", {28'h0, pb_level}, 32'h0);
    check("press_in_reset", {28'h0, pb_press}, 32'h0);
    check("tick_in_reset", {31'h0, tick}, 32'h0);
    reset = 1'b0;
    r = cyc;
    push(r + 16, 4'hF, 4'h0, 4'h0, 4'hF);
    wait_to(r + 3);
    check("tick_low_before_div", {31'h0, tick}, 32'h0);
    wait_to(r + 4);
    check("tick_first", {31'h0, tick}, 32'h1);
    wait_to(r + 5);
    check("tick_one_clock", {31'h0, tick}, 32'h0);
    wait_to(r + 15);
    check("level_not_early", {28'h0, pb_level}, 32'h0);
    wait_to(r + 20);
    check("level_all_pressed", {28'h0, pb_level}, 32'hF);
    pb = 4'hF;
    push(r + 36, 4'h0, 4'hF, 4'h0, 4'h0);
    wait_to(r + 40);

    // 2: bounce on pb[0], 8-clock halves never reach four stable ticks
    s = cyc;
    for (int k = 0; k < 25; k++) begin
      pb[0] = ~pb[0];
      repeat (8) @(negedge clock);
    end
    pb[0] = 1'b1;
    wait_to(s + 208);
    check("bounce_level", {28'h0, pb_level}, 32'h0);

    // 3: pb[1] held 100 clocks
    t = cyc;
    pb[1] = 1'b0;
    push(t + 16, 4'h2, 4'h0, 4'h0, 4'h2);
`ifdef DEBOUNCE_REPEAT_EN
    for (int k = 0; k < 7; k++) push(t + 40 + 12 * k, 4'h2, 4'h0, 4'h2, 4'h2);
`endif
    push(t + 116, 4'h0, 4'h2, 4'h0, 4'h0);
    wait_to(t + 99);
    check("ch1_held_level", {28'h0, pb_level}, 32'h2);
    wait_to(t + 100);
    pb[1] = 1'b1;
    wait_to(t + 120);

    // 4: pb[2] and pb[3] together
    u = cyc;
    pb[3:2] = 2'b00;
    push(u + 16, 4'hC, 4'h0, 4'h0, 4'hC);
    wait_to(u + 20);
    check("ch23_level", {28'h0, pb_level}, 32'hC);
    pb = 4'hF;
    push(u + 36, 4'h0, 4'hC, 4'h0, 4'h0);
    wait_to(u + 40);

    // 6: pb[0] held 60 ticks
    v = cyc;
    pb[0] = 1'b0;
    push(v + 16, 4'h1, 4'h0, 4'h0, 4'h1);
`ifdef DEBOUNCE_REPEAT_EN
    for (int k = 0; k < 18; k++) push(v + 40 + 12 * k, 4'h1, 4'h0, 4'h1, 4'h1);
`endif
    push(v + 256, 4'h0, 4'h1, 4'h0, 4'h0);
    wait_to(v + 240);
    check("ch0_long_hold", {28'h0, pb_level}, 32'h1);
    pb[0] = 1'b1;
    wait_to(v + 260);

    // 5: reset mid-count restarts the count from the new prescaler phase
    w = cyc;
    pb[0] = 1'b0;
    wait_to(w + 8);
    reset = 1'b1;
    wait_to(w + 9);
    check("level_mid_reset", {28'h0, pb_level}, 32'h0);
    check("tick_mid_reset", {31'h0, tick}, 32'h0);
    reset = 1'b0;
    r2 = cyc;
    push(r2 + 16, 4'h1, 4'h0, 4'h0, 4'h1);
    wait_to(r2 + 15);
    check("restart_not_early", {28'h0, pb_level}, 32'h0);
    wait_to(r2 + 17);
    check("restart_level", {28'h0, pb_level}, 32'h1);

    // reset while pressed drops the level with no release pulse
    wait_to(r2 + 20);
    reset = 1'b1;
    wait_to(r2 + 21);
    check("reset_drops_level", {28'h0, pb_level}, 32'h0);
    check("reset_no_release", {28'h0, pb_release}, 32'h0);
    reset = 1'b0;
    r3 = cyc;
    push(r3 + 16, 4'h1, 4'h0, 4'h0, 4'h1);
    wait_to(r3 + 20);
    pb = 4'hF;
    push(r3 + 36, 4'h0, 4'h1, 4'h0, 4'h0);
    wait_to(r3 + 40);

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
